modclk_nonoverlap_gen: RTL and testbench
========================================

# modclk_nonoverlap_gen

Parametrised, fully synchronous generator for the modulation clock set CLK_MOD / CLK_MODN / CLK_MODL. It runs on the single fabric clock and drives the ODDR2 forwarding buffers at the top level. It replaces the fixed-frequency divider, the frequency mux and the fixed shift-register patterns with a period counter. Half-period, dead time and CLKL phase are programmable at run time, and configuration changes take effect glitch-free at period boundaries.

## Interface
- CNT_W, 12 — width of HALF_PERIOD and DEAD_TIME; PHASE is CNT_W+1 bits.
- DEF_HALF_PERIOD, 8 — active half-period, in CLK_IN cycles, after reset.
- DEF_DEAD_TIME, 2 — active non-overlap delay after reset.
- DEF_PHASE, 4 — active CLKL delay, in cycles, after reset.
- CLK_IN  in  1  — fabric clock; everything runs on its rising edge.
- RESET_N  in  1  — reset is synchronous and active-low.
- ENABLE  in  1  — level; run request.
- CFG_LOAD  in  1  — one-cycle pulse that captures the three configuration inputs.
- HALF_PERIOD  in  CNT_W  — half-period request (HP).
- DEAD_TIME  in  CNT_W  — dead-time request (DT).
- PHASE  in  CNT_W+1  — CLKL delay request (PH).
- CLK_OUT_MOD  out  1  — non-overlapping phase A.
- CLK_OUT_MODN  out  1  — non-overlapping phase B.
- CLK_OUT_MODL  out  1  — 50 % square wave, delayed by PH.
- PERIOD_START  out  1  — pulse, coincident with outputs for cnt = 0.
- CFG_ACK  out  1  — pulse on the cycle a pending configuration becomes active.
- CFG_ERR  out  1  — pulse, the cycle after an illegal CFG_LOAD.
- RUNNING  out  1  — high in the RUN and STOP states.

## Operation
- **States:** IDLE, RUN, STOP.
  - IDLE→RUN when ENABLE = 1.
  - RUN→STOP when ENABLE = 0.
  - STOP→RUN when ENABLE = 1 before the wrap; the counter continues and there is no restart.
  - STOP→IDLE at the wrap (cnt = 2·HP−1).
- **Period counter cnt:** CNT_W+1 bits. It is 0 on entry to RUN, increments every cycle, and wraps 2·HP−1 → 0. It holds at 0 in IDLE.
- **Combinational output functions** (of cnt and the active configuration):
  - MOD = (DT ≤ cnt < HP).
  - MODN = (HP+DT ≤ cnt < 2·HP).
  - MODL = (((cnt − PH) mod 2·HP) < HP), computed with a conditional add of 2·HP rather than a divider.
- MOD and MODN are never high in the same cycle. Each phase has DT low cycles at the start of its half-period.
- All three clock outputs are registered. In IDLE they are forced to 0.
- **Configuration legality:** a request is legal iff 2 ≤ HP, DT < HP and PH < 2·HP.
  - Illegal: CFG_ERR pulses, nothing is captured, and any earlier pending configuration is kept.
  - Legal: the request is captured into a shadow register and marked pending. A newer legal CFG_LOAD overwrites the pending one.
- **Applying a pending configuration:**
  - In IDLE, it is applied on the next cycle.
  - In RUN or STOP, it is applied on the cycle cnt wraps to 0, so the new period starts cleanly.
  - CFG_ACK pulses on the apply cycle.
- **Reset** (RESET_N = 0 at a clock edge): state IDLE, cnt 0, active configuration = DEF_* parameters, nothing pending.
- **Output values in reset:** all outputs 0, including PERIOD_START, CFG_ACK, CFG_ERR and RUNNING.
- **Reset mid-period:** outputs drop to 0 at the next edge. A glitch-free stop is not guaranteed under reset.

## Timing
- ENABLE sampled 1 in IDLE at edge k:
  - state = RUN and cnt = 0 after edge k.
  - Registered outputs for cnt = 0, plus PERIOD_START, appear after edge k+1.
  - Latency is 2 cycles from ENABLE to the first output pattern.
- Every output pattern lags cnt by exactly 1 cycle.
- Output period is 2·HP cycles. MOD high time is HP−DT cycles; MODN high time is HP−DT cycles.
- CFG_LOAD at edge k:
  - CFG_ERR asserts after edge k+1 for one cycle.
  - In IDLE, CFG_ACK asserts after edge k+1.
- CFG_LOAD on the same cycle as the wrap: it is captured, and applied at the following wrap, not the current one.
- CFG_LOAD and an ENABLE rising edge in the same IDLE cycle: the new configuration is applied when the first RUN period starts.
- RUNNING drops on the cycle the state returns to IDLE. The last full period has already been output.

## Test plan
- **Defaults (HP = 8, DT = 2, PH = 4):** RESET_N 0→1, ENABLE = 1 →
  - period of 16 cycles;
  - MOD high for cnt 2–7, MODN high for cnt 10–15;
  - MODL rises at cnt 4;
  - PERIOD_START every 16 cycles;
  - no cycle with MOD & MODN both high.
- **Runtime change:** while running, CFG_LOAD with HP = 4, DT = 1, PH = 0 at mid-period →
  - current 16-cycle period completes;
  - CFG_ACK pulses at the wrap;
  - next period is 8 cycles with MOD at cnt 1–3, MODN at cnt 5–7, MODL at cnt 0–3.
- **Illegal configurations:** CFG_LOAD with DT = 8/HP = 8, with HP = 1, and with PH = 16/HP = 8 →
  - CFG_ERR pulses each time;
  - no CFG_ACK;
  - waveform unchanged.
- **Stop / resume:**
  - ENABLE dropped at cnt 5 → outputs continue to cnt 15, then all outputs and RUNNING go 0.
  - Repeat with ENABLE reasserted at cnt 12 → no gap, and PERIOD_START continues every 16 cycles.
- **Reset mid-run:** RESET_N = 0 at cnt 9 →
  - all outputs 0 the next cycle;
  - after release, defaults are restored even if a different configuration was active.
- **Extreme widths:**
  - HP = 2, DT = 1 → period of 4 cycles; MOD and MODN each high for 1 cycle.
  - HP = 2^CNT_W − 1 → counter wraps correctly with no overflow.

Source files
------------

// File: rtl/modclk_nonoverlap_gen_if.sv
// Control, configuration and clock-output bundle of the modulation clock generator.
// The master side drives run/config requests; the slave side returns clocks and status.
interface modclk_nonoverlap_gen_if #(
   parameter int CNT_W = 12
);
   logic             enable;
   logic             cfg_load;
   logic [CNT_W-1:0] half_period;
   logic [CNT_W-1:0] dead_time;
   logic [CNT_W:0]   phase;
   logic             clk_out_mod;
   logic             clk_out_modn;
   logic             clk_out_modl;
   logic             period_start;
   logic             cfg_ack;
   logic             cfg_err;
   logic             running;

   modport master (
      output enable, cfg_load, half_period, dead_time, phase,
      input  clk_out_mod, clk_out_modn, clk_out_modl, period_start,
      input  cfg_ack, cfg_err, running
   );

   modport slave (
      input  enable, cfg_load, half_period, dead_time, phase,
      output clk_out_mod, clk_out_modn, clk_out_modl, period_start,
      output cfg_ack, cfg_err, running
   );
endinterface

// File: rtl/modclk_nonoverlap_gen.sv
// Period-counter based generator for CLK_MOD / CLK_MODN / CLK_MODL with run-time
// configuration that is only swapped in at period boundaries (or directly while idle).
module modclk_nonoverlap_gen #(
   parameter int CNT_W           = 12,
   parameter int DEF_HALF_PERIOD = 8,
   parameter int DEF_DEAD_TIME   = 2,
   parameter int DEF_PHASE       = 4
) (
   input  logic                  i_clk_in,
   input  logic                  i_reset_n,
   modclk_nonoverlap_gen_if.slave if_mod
);
   localparam int CW = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;

   logic [CNT_W-1:0] r_hp;
   logic [CNT_W-1:0] r_dt;
   logic [CW-1:0]    r_ph;
   logic [CNT_W-1:0] r_pend_hp;
   logic [CNT_W-1:0] r_pend_dt;
   logic [CW-1:0]    r_pend_ph;
   logic             r_pend_vld;

   logic             r_mod;
   logic             r_modn;
   logic             r_modl;
   logic             r_period_start;
   logic             r_cfg_ack;
   logic             r_cfg_err;
   logic             r_running;

   logic [CW-1:0]    w_hp_x;
   logic [CW-1:0]    w_dt_x;
   logic [CW-1:0]    w_two_hp;
   logic [CW-1:0]    w_rel;
   logic             w_wrap;
   logic             w_legal;
   logic             w_mod;
   logic             w_modn;
   logic             w_modl;

   function automatic logic cfg_legal(input logic [CNT_W-1:0] hp,
                                      input logic [CNT_W-1:0] dt,
                                      input logic [CNT_W:0]   ph);
      logic [CNT_W:0] two_hp;
      two_hp = {hp, 1'b0};
      return (hp >= CNT_W'(2)) && (dt < hp) && (ph < two_hp);
   endfunction

   assign w_legal  = cfg_legal(if_mod.half_period, if_mod.dead_time, if_mod.phase);
   assign w_hp_x   = {1'b0, r_hp};
   assign w_dt_x   = {1'b0, r_dt};
   assign w_two_hp = {r_hp, 1'b0};
   assign w_wrap   = (r_state != ST_IDLE) && (r_cnt == (w_two_hp - CW'(1)));

   // Waveform decode of the current count; MODL uses a conditional add instead of a modulo.
   always_comb begin
      w_rel  = {CW{1'b0}};
      w_mod  = (r_cnt >= w_dt_x) && (r_cnt < w_hp_x);
      w_modn = (r_cnt >= (w_hp_x + w_dt_x)) && (r_cnt < w_two_hp);
      if (r_cnt < r_ph) begin
         w_rel = r_cnt - r_ph + w_two_hp;
      end else begin
         w_rel = r_cnt - r_ph;
      end
      w_modl = (w_rel < w_hp_x);
   end

   // Run-state next-state and counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = {CW{1'b0}};
            if (if_mod.enable) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            w_cnt_nxt = w_wrap ? {CW{1'b0}} : (r_cnt + CW'(1));
            if (!if_mod.enable) begin
               w_state_nxt = ST_STOP;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_STOP: begin
            w_cnt_nxt = w_wrap ? {CW{1'b0}} : (r_cnt + CW'(1));
            // Re-enable resumes the running period; otherwise finish it and park.
            if (if_mod.enable) begin
               w_state_nxt = ST_RUN;
            end else if (w_wrap) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_STOP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = {CW{1'b0}};
         end
      endcase
   end

   // State and period counter registers.
   always_ff @(posedge i_clk_in) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Configuration shadow/active registers with boundary-aligned apply.
   always_ff @(posedge i_clk_in) begin
      if (!i_reset_n) begin
         r_hp       <= CNT_W'(DEF_HALF_PERIOD);
         r_dt       <= CNT_W'(DEF_DEAD_TIME);
         r_ph       <= CW'(DEF_PHASE);
         r_pend_hp  <= {CNT_W{1'b0}};
         r_pend_dt  <= {CNT_W{1'b0}};
         r_pend_ph  <= {CW{1'b0}};
         r_pend_vld <= 1'b0;
         r_cfg_ack  <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_cfg_ack <= 1'b0;
         r_cfg_err <= if_mod.cfg_load && !w_legal;
         if ((r_state == ST_IDLE) && if_mod.cfg_load && w_legal) begin
            r_hp       <= if_mod.half_period;
            r_dt       <= if_mod.dead_time;
            r_ph       <= if_mod.phase;
            r_pend_vld <= 1'b0;
            r_cfg_ack  <= 1'b1;
         end else begin
            if (((r_state == ST_IDLE) || w_wrap) && r_pend_vld) begin
               r_hp       <= r_pend_hp;
               r_dt       <= r_pend_dt;
               r_ph       <= r_pend_ph;
               r_pend_vld <= 1'b0;
               r_cfg_ack  <= 1'b1;
            end
            // A load on the wrap cycle lands in the shadow and waits for the next wrap.
            if (if_mod.cfg_load && w_legal) begin
               r_pend_hp  <= if_mod.half_period;
               r_pend_dt  <= if_mod.dead_time;
               r_pend_ph  <= if_mod.phase;
               r_pend_vld <= 1'b1;
            end
         end
      end
   end

   // Registered clock outputs, one cycle behind the counter, forced low while idle.
   always_ff @(posedge i_clk_in) begin
      if (!i_reset_n) begin
         r_mod          <= 1'b0;
         r_modn         <= 1'b0;
         r_modl         <= 1'b0;
         r_period_start <= 1'b0;
         r_running      <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_mod          <= 1'b0;
         r_modn         <= 1'b0;
         r_modl         <= 1'b0;
         r_period_start <= 1'b0;
         r_running      <= 1'b0;
      end else begin
         r_mod          <= w_mod;
         r_modn         <= w_modn;
         r_modl         <= w_modl;
         r_period_start <= (r_cnt == {CW{1'b0}});
         r_running      <= 1'b1;
      end
   end

   assign if_mod.clk_out_mod  = r_mod;
   assign if_mod.clk_out_modn = r_modn;
   assign if_mod.clk_out_modl = r_modl;
   assign if_mod.period_start = r_period_start;
   assign if_mod.cfg_ack      = r_cfg_ack;
   assign if_mod.cfg_err      = r_cfg_err;
   assign if_mod.running      = r_running;
endmodule

// File: tb/tb_modclk_nonoverlap_gen.sv
// Directed bench: per-period expected waveforms as bit masks indexed by count,
// plus hand sequences for idle load, stop, reset and the widest half-period.
module tb_modclk_nonoverlap_gen;
   localparam int CNT_W = 12;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   modclk_nonoverlap_gen_if #(.CNT_W(CNT_W)) bus ();

   modclk_nonoverlap_gen #(
      .CNT_W(CNT_W), .DEF_HALF_PERIOD(8), .DEF_DEAD_TIME(2), .DEF_PHASE(4)
   ) u_dut (
      .i_clk_in  (clk),
      .i_reset_n (rst_n),
      .if_mod    (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          len;
      logic [15:0] mod;
      logic [15:0] modn;
      logic [15:0] modl;
      logic [15:0] ack;
      logic [15:0] err;
      int          load_at;
      logic [11:0] hp;
      logic [11:0] dt;
      logic [12:0] ph;
      int          en_drop;
      int          en_rise;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(input int len, input logic [15:0] mod, input logic [15:0] modn,
                               input logic [15:0] modl, input logic [15:0] ack,
                               input logic [15:0] err, input int load_at, input logic [11:0] hp,
                               input logic [11:0] dt, input logic [12:0] ph,
                               input int en_drop, input int en_rise);
      vec_t v;
      v.len = len; v.mod = mod; v.modn = modn; v.modl = modl; v.ack = ack; v.err = err;
      v.load_at = load_at; v.hp = hp; v.dt = dt; v.ph = ph;
      v.en_drop = en_drop; v.en_rise = en_rise;
      return v;
   endfunction

   task automatic nxt();
      @(negedge clk);
   endtask

   // {period_start, mod, modn, modl, cfg_ack, cfg_err, running}
   function automatic logic [6:0] snap();
      return {bus.period_start, bus.clk_out_mod, bus.clk_out_modn, bus.clk_out_modl,
              bus.cfg_ack, bus.cfg_err, bus.running};
   endfunction

   task automatic chk7(input string name, input logic [6:0] got, input logic [6:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b expected %b (ps,mod,modn,modl,ack,err,run)",
                  name, $time, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // Starts on the sample point of display cycle 0 and ends on the next period's cycle 0.
   task automatic run_vec(input vec_t v, input int id);
      logic [6:0] exp;
      for (int c = 0; c < v.len; c++) begin
         exp = {(c == 0), v.mod[c], v.modn[c], v.modl[c], v.ack[c], v.err[c], 1'b1};
         chk7($sformatf("p%0d_c%0d", id, c), snap(), exp);
         bus.cfg_load = 1'b0;
         if (c == v.load_at) begin
            bus.cfg_load    = 1'b1;
            bus.half_period = v.hp;
            bus.dead_time   = v.dt;
            bus.phase       = v.ph;
         end
         if (c == v.en_drop) bus.enable = 1'b0;
         if (c == v.en_rise) bus.enable = 1'b1;
         nxt();
      end
      bus.cfg_load = 1'b0;
   endtask

   initial begin
      int found;
      int mod_c;
      int modn_c;
      int modl_c;
      int ps_c;
      int ovl_c;

      tbl[0]  = mk(16, 16'h00FC, 16'hFC00, 16'h0FF0, 16'h0000, 16'h0000, -1, 12'd0, 12'd0, 13'd0, -1, -1);
      tbl[1]  = mk(16, 16'h00FC, 16'hFC00, 16'h0FF0, 16'h8000, 16'h0000,  6, 12'd4, 12'd1, 13'd0, -1, -1);
      tbl[2]  = mk(8,  16'h000E, 16'h00E0, 16'h000F, 16'h0000, 16'h0000, -1, 12'd0, 12'd0, 13'd0, -1, -1);
      tbl[3]  = mk(8,  16'h000E, 16'h00E0, 16'h000F, 16'h0000, 16'h0004,  1, 12'd8, 12'd8, 13'd4, -1, -1);
      tbl[4]  = mk(8,  16'h000E, 16'h00E0, 16'h000F, 16'h0000, 16'h0010,  3, 12'd1, 12'd0, 13'd0, -1, -1);
      tbl[5]  = mk(8,  16'h000E, 16'h00E0, 16'h000F, 16'h0000, 16'h0040,  5, 12'd8, 12'd2, 13'd16, -1, -1);
      tbl[6]  = mk(8,  16'h000E, 16'h00E0, 16'h000F, 16'h0000, 16'h0000,  6, 12'd2, 12'd1, 13'd0, -1, -1);
      tbl[7]  = mk(8,  16'h000E, 16'h00E0, 16'h000F, 16'h0080, 16'h0000, -1, 12'd0, 12'd0, 13'd0, -1, -1);
      tbl[8]  = mk(4,  16'h0002, 16'h0008, 16'h0003, 16'h0000, 16'h0000, -1, 12'd0, 12'd0, 13'd0, -1, -1);
      tbl[9]  = mk(4,  16'h0002, 16'h0008, 16'h0003, 16'h0008, 16'h0000,  1, 12'd8, 12'd2, 13'd4, -1, -1);
      tbl[10] = mk(16, 16'h00FC, 16'hFC00, 16'h0FF0, 16'h0000, 16'h0000, -1, 12'd0, 12'd0, 13'd0, -1, -1);
      tbl[11] = mk(16, 16'h00FC, 16'hFC00, 16'h0FF0, 16'h0000, 16'h0000, -1, 12'd0, 12'd0, 13'd0,  4, 11);
      tbl[12] = mk(16, 16'h00FC, 16'hFC00, 16'h0FF0, 16'h0000, 16'h0000, -1, 12'd0, 12'd0, 13'd0,  4, -1);

      rst_n           = 1'b0;
      bus.enable      = 1'b0;
      bus.cfg_load    = 1'b0;
      bus.half_period = 12'd0;
      bus.dead_time   = 12'd0;
      bus.phase       = 13'd0;
      nxt(); nxt(); nxt();
      chk7("reset", snap(), 7'b0000000);
      rst_n = 1'b1;
      nxt();
      chk7("idle", snap(), 7'b0000000);
      bus.enable = 1'b1;
      nxt();
      chk7("start_latency", snap(), 7'b0000000);
      nxt();

      for (int i = 0; i < 13; i++) begin
         run_vec(tbl[i], i);
      end
      chk7("stopped", snap(), 7'b0000000);
      nxt();
      chk7("idle_hold", snap(), 7'b0000000);

      // Load and enable together in idle: the first period must use the new setting.
      bus.cfg_load    = 1'b1;
      bus.half_period = 12'd4;
      bus.dead_time   = 12'd1;
      bus.phase       = 13'd0;
      bus.enable      = 1'b1;
      nxt();
      bus.cfg_load = 1'b0;
      chk7("idle_load_ack", snap(), 7'b0000100);
      nxt();
      run_vec(tbl[2], 20);

      // Reset mid-period, then defaults must come back.
      nxt(); nxt(); nxt();
      rst_n = 1'b0;
      nxt();
      chk7("reset_midrun", snap(), 7'b0000000);
      nxt();
      chk7("reset_hold", snap(), 7'b0000000);
      rst_n = 1'b1;
      nxt();
      chk7("restart_latency", snap(), 7'b0000000);
      nxt();
      run_vec(tbl[0], 30);

      // Widest half-period: HP=4095, DT=5 -> 8190-cycle period, 4090 high cycles per phase.
      bus.cfg_load    = 1'b1;
      bus.half_period = 12'd4095;
      bus.dead_time   = 12'd5;
      bus.phase       = 13'd0;
      nxt();
      bus.cfg_load = 1'b0;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.period_start === 1'b1) begin
            found = 1;
            break;
         end
         nxt();
      end
      chk_int("big_period_start_seen", found, 1);
      mod_c = 0; modn_c = 0; modl_c = 0; ps_c = 0; ovl_c = 0;
      for (int i = 0; i < 8190; i++) begin
         mod_c  += int'(bus.clk_out_mod);
         modn_c += int'(bus.clk_out_modn);
         modl_c += int'(bus.clk_out_modl);
         ps_c   += int'(bus.period_start);
         ovl_c  += int'(bus.clk_out_mod & bus.clk_out_modn);
         nxt();
      end
      chk_int("big_mod_high", mod_c, 4090);
      chk_int("big_modn_high", modn_c, 4090);
      chk_int("big_modl_high", modl_c, 4095);
      chk_int("big_ps_count", ps_c, 1);
      chk_int("big_overlap", ovl_c, 0);
      chk_int("big_wrap_ps", int'(bus.period_start), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
